// File: rtl/udp_img_pkg.sv
// Shared encodings and frame geometry for the GMII UDP image transmitter.
package udp_img_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CHECK_SUM,
        PREAMBLE,
        ETH_HEAD,
        IP_HEAD,
        UDP_HEAD,
        TX_DATA,
        PAD,
        CRC
    } tx_state_t;

    localparam logic [15:0] CHECK_SUM_CYCLES = 16'd3;
    localparam logic [15:0] PREAMBLE_BYTES   = 16'd8;
    localparam logic [15:0] ETH_BYTES        = 16'd14;
    localparam logic [15:0] IP_BYTES         = 16'd20;
    localparam logic [15:0] UDP_BYTES        = 16'd8;
    localparam logic [15:0] CRC_BYTES        = 16'd4;

    localparam logic [15:0] MAX_PAYLOAD = 16'd1472;
    localparam logic [15:0] MIN_PAYLOAD = 16'd18;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

    // One's-complement end-around carry fold of a 32-bit partial sum.
    function automatic logic [31:0] fold_carry(input logic [31:0] s);
        return {16'h0000, s[15:0]} + {16'h0000, s[31:16]};
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Reflected CRC-32 (Ethernet FCS) advancing one byte per enabled cycle, LSB bit first.
module crc32_d8
    import udp_img_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        crc_en,
    input  logic        crc_clr,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] stage [0:8];

    assign stage[0] = crc;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bit
            assign stage[gi+1] = (stage[gi] >> 1)
                               ^ (((stage[gi][0] ^ data[gi]) == 1'b1) ? CRC_POLY_REFL : 32'h0000_0000);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC_INIT;
        end else if (crc_clr) begin
            crc <= CRC_INIT;
        end else if (crc_en) begin
            crc <= stage[8];
        end
    end

endmodule

// File: rtl/udp_img_tx.sv
// Streams one UDP/IPv4 packet over GMII: preamble, headers with computed IP checksum,
// FIFO-fed payload, zero padding up to the Ethernet minimum, then the FCS.
module udp_img_tx
    import udp_img_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55,
    parameter logic [47:0] DES_MAC    = 48'hff_ff_ff_ff_ff_ff,
    parameter logic [31:0] BOARD_IP   = {8'd192, 8'd168, 8'd1, 8'd10},
    parameter logic [31:0] DES_IP     = {8'd192, 8'd168, 8'd1, 8'd102},
    parameter logic [15:0] BOARD_PORT = 16'd1234,
    parameter logic [15:0] DES_PORT   = 16'd1234
) (
    input  logic        eth_tx_clk,
    input  logic        rst_n,
    input  logic        tx_start_en,
    input  logic [15:0] tx_byte_num,
    input  logic [31:0] tx_data,
    output logic        tx_req,
    output logic        tx_done,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd
);

    tx_state_t   state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [15:0] len_reg;
    logic [15:0] ident_reg;
    logic [31:0] sum_reg;
    logic [15:0] csum_reg;
    logic [31:0] data_reg;
    logic        done_pending_reg;

    logic [7:0]  byte_next;
    logic        tx_en_next, req_next;
    logic        crc_en, crc_clr, load_word, frame_end;
    logic [31:0] crc_val;

    logic [15:0]  total_len, udp_len, words_total, word_idx_next;
    logic [31:0]  ip_sum, sum_folded;
    logic [111:0] eth_hdr, eth_shift;
    logic [159:0] ip_hdr, ip_shift;
    logic [63:0]  udp_hdr, udp_shift;
    logic [31:0]  data_shift, crc_shift;
    logic         more_words;

    assign total_len = IP_BYTES + UDP_BYTES + len_reg;
    assign udp_len   = UDP_BYTES + len_reg;

    assign ip_sum = 32'h0000_4500 + {16'h0000, total_len} + {16'h0000, ident_reg} + 32'h0000_4000
                  + {16'h0000, 8'h40, IP_PROTO_UDP}
                  + {16'h0000, BOARD_IP[31:16]} + {16'h0000, BOARD_IP[15:0]}
                  + {16'h0000, DES_IP[31:16]}   + {16'h0000, DES_IP[15:0]};
    assign sum_folded = fold_carry(sum_reg);

    assign eth_hdr = {DES_MAC, BOARD_MAC, ETHERTYPE_IPV4};
    assign ip_hdr  = {16'h4500, total_len, ident_reg, 16'h4000, 8'h40, IP_PROTO_UDP,
                      csum_reg, BOARD_IP, DES_IP};
    assign udp_hdr = {BOARD_PORT, DES_PORT, udp_len, 16'h0000};

    // Each header is shifted so the byte at the current index lands in the top lane.
    assign eth_shift  = eth_hdr  << {cnt_reg[3:0], 3'b000};
    assign ip_shift   = ip_hdr   << {cnt_reg[4:0], 3'b000};
    assign udp_shift  = udp_hdr  << {cnt_reg[2:0], 3'b000};
    assign data_shift = data_reg << {cnt_reg[1:0], 3'b000};
    assign crc_shift  = (~crc_val) >> {cnt_reg[1:0], 3'b000};

    assign words_total   = (len_reg + 16'd3) >> 2;
    assign word_idx_next = {2'b00, cnt_reg[15:2]} + 16'd1;
    assign more_words    = (word_idx_next < words_total);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 16'd1;
        byte_next  = 8'h00;
        tx_en_next = 1'b0;
        req_next   = 1'b0;
        crc_en     = 1'b0;
        crc_clr    = 1'b0;
        load_word  = 1'b0;
        frame_end  = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = 16'd0;
                crc_clr  = 1'b1;
                if (tx_start_en) begin
                    state_next = CHECK_SUM;
                end
            end
            CHECK_SUM: begin
                if (cnt_reg == CHECK_SUM_CYCLES - 16'd1) begin
                    state_next = PREAMBLE;
                    cnt_next   = 16'd0;
                end
            end
            PREAMBLE: begin
                tx_en_next = 1'b1;
                byte_next  = (cnt_reg == PREAMBLE_BYTES - 16'd1) ? 8'hD5 : 8'h55;
                if (cnt_reg == PREAMBLE_BYTES - 16'd1) begin
                    state_next = ETH_HEAD;
                    cnt_next   = 16'd0;
                end
            end
            ETH_HEAD: begin
                tx_en_next = 1'b1;
                crc_en     = 1'b1;
                byte_next  = eth_shift[111:104];
                if (cnt_reg == ETH_BYTES - 16'd1) begin
                    state_next = IP_HEAD;
                    cnt_next   = 16'd0;
                end
            end
            IP_HEAD: begin
                tx_en_next = 1'b1;
                crc_en     = 1'b1;
                byte_next  = ip_shift[159:152];
                if (cnt_reg == IP_BYTES - 16'd1) begin
                    state_next = UDP_HEAD;
                    cnt_next   = 16'd0;
                end
            end
            UDP_HEAD: begin
                tx_en_next = 1'b1;
                crc_en     = 1'b1;
                byte_next  = udp_shift[63:56];
                req_next   = (cnt_reg == UDP_BYTES - 16'd3) && (len_reg != 16'd0);
                if (cnt_reg == UDP_BYTES - 16'd1) begin
                    cnt_next = 16'd0;
                    if (len_reg != 16'd0) begin
                        state_next = TX_DATA;
                        load_word  = 1'b1;
                    end else begin
                        state_next = PAD;
                    end
                end
            end
            TX_DATA: begin
                tx_en_next = 1'b1;
                crc_en     = 1'b1;
                byte_next  = data_shift[31:24];
                // Strobe one cycle ahead of the registered pin so the word lands by lane 3.
                req_next   = (cnt_reg[1:0] == 2'd1) && more_words;
                load_word  = (cnt_reg[1:0] == 2'd3);
                if (cnt_reg == len_reg - 16'd1) begin
                    cnt_next   = 16'd0;
                    state_next = (len_reg < MIN_PAYLOAD) ? PAD : CRC;
                end
            end
            PAD: begin
                tx_en_next = 1'b1;
                crc_en     = 1'b1;
                if (cnt_reg + len_reg == MIN_PAYLOAD - 16'd1) begin
                    state_next = CRC;
                    cnt_next   = 16'd0;
                end
            end
            CRC: begin
                tx_en_next = 1'b1;
                byte_next  = crc_shift[7:0];
                if (cnt_reg == CRC_BYTES - 16'd1) begin
                    state_next = IDLE;
                    cnt_next   = 16'd0;
                    frame_end  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge eth_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            cnt_reg          <= 16'd0;
            len_reg          <= 16'd0;
            ident_reg        <= 16'd0;
            sum_reg          <= 32'd0;
            csum_reg         <= 16'd0;
            data_reg         <= 32'd0;
            done_pending_reg <= 1'b0;
            tx_done          <= 1'b0;
            tx_req           <= 1'b0;
            gmii_tx_en       <= 1'b0;
            gmii_txd         <= 8'h00;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            tx_req     <= req_next;
            gmii_tx_en <= tx_en_next;
            gmii_txd   <= byte_next;
            // tx_done trails the last FCS byte on the pins by one cycle.
            done_pending_reg <= frame_end;
            tx_done          <= done_pending_reg;
            if (state_reg == IDLE && tx_start_en) begin
                len_reg <= (tx_byte_num > MAX_PAYLOAD) ? MAX_PAYLOAD : tx_byte_num;
            end
            if (state_reg == CHECK_SUM) begin
                case (cnt_reg[1:0])
                    2'd0:    sum_reg  <= ip_sum;
                    2'd1:    sum_reg  <= sum_folded;
                    default: csum_reg <= ~sum_folded[15:0];
                endcase
            end
            if (load_word) begin
                data_reg <= tx_data;
            end
            if (frame_end) begin
                ident_reg <= ident_reg + 16'd1;
            end
        end
    end

    crc32_d8 u_crc (
        .clk     (eth_tx_clk),
        .rst_n   (rst_n),
        .crc_en  (crc_en),
        .crc_clr (crc_clr),
        .data    (byte_next),
        .crc     (crc_val)
    );

endmodule

// File: tb/tb_udp_img_tx.sv
// Scoreboard bench: a software frame model queues every expected GMII byte, and the
// pins are popped and compared byte by byte along with strobe counts and tx_done timing.
module tb_udp_img_tx;

    localparam logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55;
    localparam logic [47:0] DES_MAC    = 48'hff_ff_ff_ff_ff_ff;
    localparam logic [31:0] BOARD_IP   = {8'd192, 8'd168, 8'd1, 8'd10};
    localparam logic [31:0] DES_IP     = {8'd192, 8'd168, 8'd1, 8'd102};
    localparam logic [15:0] BOARD_PORT = 16'd1234;
    localparam logic [15:0] DES_PORT   = 16'd1234;

    logic        eth_tx_clk = 1'b0;
    logic        rst_n;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic [31:0] tx_data;
    logic        tx_req;
    logic        tx_done;
    logic        gmii_tx_en;
    logic [7:0]  gmii_txd;

    always #4 eth_tx_clk = ~eth_tx_clk;

    udp_img_tx dut (
        .eth_tx_clk  (eth_tx_clk),
        .rst_n       (rst_n),
        .tx_start_en (tx_start_en),
        .tx_byte_num (tx_byte_num),
        .tx_data     (tx_data),
        .tx_req      (tx_req),
        .tx_done     (tx_done),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_txd    (gmii_txd)
    );

    logic [7:0]  exp_q[$];
    logic [7:0]  body_q[$];
    logic [31:0] words[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] ident_model = 16'd0;

    task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
        end
    endtask

    task automatic push16(input logic [15:0] v);
        body_q.push_back(v[15:8]);
        body_q.push_back(v[7:0]);
    endtask

    task automatic push32(input logic [31:0] v);
        push16(v[31:16]);
        push16(v[15:0]);
    endtask

    task automatic push48(input logic [47:0] v);
        push16(v[47:32]);
        push32(v[31:0]);
    endtask

    task automatic build_frame(input int n, input logic [15:0] id);
        logic [31:0] sum;
        logic [31:0] crc;
        logic [31:0] w;
        logic [15:0] csum;
        body_q.delete();
        push48(DES_MAC);
        push48(BOARD_MAC);
        push16(16'h0800);
        push16(16'h4500);
        push16(16'(28 + n));
        push16(id);
        push16(16'h4000);
        body_q.push_back(8'h40);
        body_q.push_back(8'h11);
        push16(16'h0000);
        push32(BOARD_IP);
        push32(DES_IP);
        sum = 32'd0;
        for (int k = 0; k < 10; k++) sum += {16'h0000, body_q[14 + 2*k], body_q[15 + 2*k]};
        while (sum[31:16] != 16'h0000) sum = {16'h0000, sum[15:0]} + {16'h0000, sum[31:16]};
        csum = ~sum[15:0];
        body_q[24] = csum[15:8];
        body_q[25] = csum[7:0];
        push16(BOARD_PORT);
        push16(DES_PORT);
        push16(16'(8 + n));
        push16(16'h0000);
        for (int i = 0; i < n; i++) begin
            w = words[i/4];
            w = w << (8 * (i % 4));
            body_q.push_back(w[31:24]);
        end
        for (int i = n; i < 18; i++) body_q.push_back(8'h00);
        crc = 32'hFFFF_FFFF;
        foreach (body_q[i]) begin
            crc = crc ^ {24'h000000, body_q[i]};
            for (int b = 0; b < 8; b++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB8_8320) : (crc >> 1);
        end
        crc = ~crc;
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        foreach (body_q[i]) exp_q.push_back(body_q[i]);
        exp_q.push_back(crc[7:0]);
        exp_q.push_back(crc[15:8]);
        exp_q.push_back(crc[23:16]);
        exp_q.push_back(crc[31:24]);
    endtask

    task automatic run_frame(input int n_req, input int inject_at, input int abort_at);
        int n, exp_total, exp_req, req_cnt, done_cnt, bytes_seen, widx, tail;
        bit en_prev, injected, aborted;
        logic [7:0] e;
        n = (n_req > 1472) ? 1472 : n_req;
        build_frame(n, ident_model);
        exp_total = exp_q.size();
        exp_req = (n + 3) / 4;
        req_cnt = 0; done_cnt = 0; bytes_seen = 0; widx = 0; tail = 0;
        en_prev = 1'b0; injected = 1'b0; aborted = 1'b0;
        @(negedge eth_tx_clk);
        tx_start_en = 1'b1;
        tx_byte_num = 16'(n_req);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge eth_tx_clk);
            tx_start_en = 1'b0;
            if (gmii_tx_en) begin
                if (exp_q.size() == 0) begin
                    check("extra_byte", bytes_seen, 32'(gmii_tx_en), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("gmii_txd", bytes_seen, 32'(gmii_txd), 32'(e));
                end
                bytes_seen++;
            end
            if (tx_req) begin
                tx_data = (widx < words.size()) ? words[widx] : 32'h0;
                widx++;
                req_cnt++;
            end
            if (tx_done) begin
                done_cnt++;
                check("done_timing", done_cnt, 32'({en_prev, gmii_tx_en}), 32'd2);
            end
            en_prev = gmii_tx_en;
            if (inject_at >= 0 && !injected && bytes_seen == inject_at) begin
                tx_start_en = 1'b1;
                tx_byte_num = 16'd100;
                injected = 1'b1;
            end
            if (abort_at >= 0 && bytes_seen == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_tx_en", bytes_seen, 32'(gmii_tx_en), 32'd0);
                aborted = 1'b1;
                break;
            end
            if (done_cnt > 0) begin
                tail++;
                if (tail == 20) break;
            end
        end
        if (aborted) begin
            repeat (2) @(negedge eth_tx_clk);
            rst_n = 1'b1;
            done_cnt = 0;
            repeat (20) begin
                @(negedge eth_tx_clk);
                if (tx_done) done_cnt++;
            end
            check("abort_no_done", n, done_cnt, 0);
            exp_q.delete();
            ident_model = 16'd0;
            $display("frame n=%0d aborted after %0d bytes", n_req, bytes_seen);
        end else begin
            check("tx_done_count", n, done_cnt, 1);
            check("bytes_left", n, exp_q.size(), 0);
            check("frame_bytes", n, bytes_seen, exp_total);
            check("tx_req_count", n, req_cnt, exp_req);
            ident_model++;
            $display("frame n=%0d bytes=%0d tx_req=%0d tx_done=%0d", n_req, bytes_seen, req_cnt, done_cnt);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        tx_start_en = 1'b0;
        tx_byte_num = 16'd0;
        tx_data = 32'd0;
        repeat (3) @(negedge eth_tx_clk);
        check("rst_gmii_tx_en", 0, 32'(gmii_tx_en), 32'd0);
        check("rst_gmii_txd", 0, 32'(gmii_txd), 32'd0);
        check("rst_tx_req", 0, 32'(tx_req), 32'd0);
        check("rst_tx_done", 0, 32'(tx_done), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge eth_tx_clk);

        words.delete();
        words.push_back(32'hDEADBEEF);
        run_frame(4, -1, -1);

        words.delete();
        run_frame(0, -1, -1);

        words.delete();
        words.push_back($urandom);
        words.push_back($urandom);
        run_frame(6, -1, -1);

        words.delete();
        for (int i = 0; i < 244; i++)
            words.push_back({8'(4*i), 8'(4*i + 1), 8'(4*i + 2), 8'(4*i + 3)});
        run_frame(976, -1, -1);

        words.delete();
        for (int i = 0; i < 10; i++) words.push_back($urandom);
        run_frame(40, 70, -1);

        words.delete();
        for (int i = 0; i < 368; i++) words.push_back($urandom);
        run_frame(2000, -1, -1);

        words.delete();
        for (int i = 0; i < 3; i++) words.push_back($urandom);
        run_frame(10, -1, 28);
        run_frame(10, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
